// File: rtl/pool2x2_stream.sv
// pool2x2_stream
// 2x2, stride-2 max/average pooling over a raster-order pixel stream.
// Each pixel has CH independent lanes of DW unsigned bits. The column count,
// row count and pooling mode are latched when a frame starts.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   en         frame enable, held high for the whole frame; low aborts
//   mode       0 = max, 1 = average (latched at frame start)
//   col, row   frame geometry in pixels (latched at frame start)
//   valid_in   data_in carries a pixel this cycle
//   data_in    pixel, lane k in bits [k*DW +: DW]
//   data_out   pooled pixel, same lane layout, holds between pulses
//   valid_out  one-cycle pulse per pooled pixel
//   pool_end   pulse coincident with the last valid_out of a frame
//   busy       frame in progress (RUN state)
//   cfg_err    illegal configuration seen (ERR state)
//
// Handshake: there is no backpressure. A beat is consumed on every rising
// edge where the block is in RUN, en=1 and valid_in=1; every other beat is
// dropped. valid_out is a single-cycle qualifier for data_out.
module pool2x2_stream #(
    parameter int CH      = 12,
    parameter int DW      = 8,
    parameter int MAX_COL = 64,
    parameter int CW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [CW-1:0]    col,
    input  logic [CW-1:0]    row,
    input  logic             valid_in,
    input  logic [CH*DW-1:0] data_in,
    output logic [CH*DW-1:0] data_out,
    output logic             valid_out,
    output logic             pool_end,
    output logic             busy,
    output logic             cfg_err
);

    localparam int LBD = MAX_COL / 2;
    localparam int AW  = (LBD > 1) ? $clog2(LBD) : 1;
    localparam int HW  = DW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             mode_q, mode_d;
    logic [CW-1:0]    col_q, col_d;
    logic [CW-1:0]    row_q, row_d;
    logic [CW-1:0]    c_cnt_q, c_cnt_d;
    logic [CW-1:0]    r_cnt_q, r_cnt_d;
    logic [CH*DW-1:0] hold_q, hold_d;
    logic [CH*DW-1:0] data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;
    logic             pool_end_q, pool_end_d;

    // One entry per horizontal pair of a row; holds the even-row partials.
    logic [CH*HW-1:0] line_buf_q [LBD];
    logic [CH*HW-1:0] lb_rdata;
    logic             lb_we;
    logic [AW-1:0]    lb_idx;

    logic [CH*HW-1:0] h_vec;
    logic [CH*DW-1:0] out_vec;

    logic [DW-1:0]    pix_k;
    logic [DW-1:0]    hold_k;
    logic [HW-1:0]    h_k;
    logic [HW-1:0]    buf_k;
    logic [DW+1:0]    s_k;
    logic [DW-1:0]    o_k;

    logic             cfg_ok;
    logic             col_wrap;
    logic             last_row;

    assign lb_idx   = c_cnt_q[AW:1];
    assign lb_rdata = line_buf_q[lb_idx];

    assign cfg_ok = (col[0] == 1'b0) && (col >= CW'(2)) && (col <= CW'(MAX_COL)) &&
                    (row[0] == 1'b0) && (row >= CW'(2));

    assign col_wrap = (c_cnt_q == col_q - CW'(1));
    assign last_row = (r_cnt_q == row_q - CW'(1));

    // Per-lane datapath: horizontal pair h, then vertical combine with the
    // buffered even-row partial. Average sums stay wide until the final >>2.
    always_comb begin
        h_vec   = '0;
        out_vec = '0;
        pix_k   = '0;
        hold_k  = '0;
        h_k     = '0;
        buf_k   = '0;
        s_k     = '0;
        o_k     = '0;
        for (int k = 0; k < CH; k++) begin
            pix_k  = data_in[k*DW +: DW];
            hold_k = hold_q[k*DW +: DW];
            buf_k  = lb_rdata[k*HW +: HW];
            if (mode_q) begin
                h_k = {1'b0, hold_k} + {1'b0, pix_k};
                s_k = {1'b0, buf_k} + {1'b0, h_k};
                o_k = DW'(s_k >> 2);
            end else begin
                h_k = (pix_k > hold_k) ? {1'b0, pix_k} : {1'b0, hold_k};
                s_k = '0;
                o_k = (h_k > buf_k) ? h_k[DW-1:0] : buf_k[DW-1:0];
            end
            h_vec[k*HW +: HW]   = h_k;
            out_vec[k*DW +: DW] = o_k;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        col_d       = col_q;
        row_d       = row_q;
        c_cnt_d     = c_cnt_q;
        r_cnt_d     = r_cnt_q;
        hold_d      = hold_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        pool_end_d  = 1'b0;
        lb_we       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    mode_d  = mode;
                    col_d   = col;
                    row_d   = row;
                    c_cnt_d = '0;
                    r_cnt_d = '0;
                    hold_d  = '0;
                    state_d = cfg_ok ? RUN : ERR;
                end
            end

            ERR: begin
                if (!en) begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                if (!en) begin
                    // Abort: anything presented this cycle is dropped.
                    state_d = IDLE;
                    c_cnt_d = '0;
                    r_cnt_d = '0;
                    hold_d  = '0;
                end else if (valid_in) begin
                    if (!c_cnt_q[0]) begin
                        hold_d = data_in;
                    end else if (!r_cnt_q[0]) begin
                        lb_we = 1'b1;
                    end else begin
                        data_out_d  = out_vec;
                        valid_out_d = 1'b1;
                        pool_end_d  = col_wrap && last_row;
                    end

                    if (col_wrap) begin
                        c_cnt_d = '0;
                        if (last_row) begin
                            r_cnt_d = '0;
                            state_d = IDLE;
                        end else begin
                            r_cnt_d = r_cnt_q + CW'(1);
                        end
                    end else begin
                        c_cnt_d = c_cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            c_cnt_q     <= '0;
            r_cnt_q     <= '0;
            hold_q      <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            pool_end_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            col_q       <= col_d;
            row_q       <= row_d;
            c_cnt_q     <= c_cnt_d;
            r_cnt_q     <= r_cnt_d;
            hold_q      <= hold_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            pool_end_q  <= pool_end_d;
        end
    end

    // The buffer needs no reset: an odd row only ever reads entries written
    // by the even row just before it in the same frame.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf_q[lb_idx] <= h_vec;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign pool_end  = pool_end_q;
    assign busy      = (state_q == RUN);
    assign cfg_err   = (state_q == ERR);

endmodule

// File: tb/tb_pool2x2_stream.sv
// Testbench for pool2x2_stream, built with CH=2, DW=8.
module tb_pool2x2_stream;

    localparam int CH      = 2;
    localparam int DW      = 8;
    localparam int MAX_COL = 64;
    localparam int CW      = 16;
    localparam int W       = CH * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          mode;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          valid_in;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic          valid_out;
    logic          pool_end;
    logic          busy;
    logic          cfg_err;

    pool2x2_stream #(
        .CH(CH), .DW(DW), .MAX_COL(MAX_COL), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .col(col), .row(row),
        .valid_in(valid_in), .data_in(data_in), .data_out(data_out),
        .valid_out(valid_out), .pool_end(pool_end), .busy(busy), .cfg_err(cfg_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    bit           got_end_q[$];
    int           got_cyc_q[$];
    int           stray_end = 0;
    logic [W-1:0] frame_px[$];

    always @(negedge clk) begin
        if (valid_out) begin
            got_q.push_back(data_out);
            got_end_q.push_back(pool_end);
            got_cyc_q.push_back(cyc);
        end else if (pool_end) begin
            stray_end++;
        end
    end

    // Reference pooling computed directly from the 2x2 windows of frame_px.
    function automatic void model(input bit m, input int c, input int r);
        logic [W-1:0] p0, p1, p2, p3, w;
        int a, b, cc, d, v;
        exp_q.delete();
        for (int pr = 0; pr < r / 2; pr++) begin
            for (int pc = 0; pc < c / 2; pc++) begin
                p0 = frame_px[(2*pr)*c + 2*pc];
                p1 = frame_px[(2*pr)*c + 2*pc + 1];
                p2 = frame_px[(2*pr+1)*c + 2*pc];
                p3 = frame_px[(2*pr+1)*c + 2*pc + 1];
                w  = '0;
                for (int k = 0; k < CH; k++) begin
                    a  = int'(p0[k*DW +: DW]);
                    b  = int'(p1[k*DW +: DW]);
                    cc = int'(p2[k*DW +: DW]);
                    d  = int'(p3[k*DW +: DW]);
                    if (m) begin
                        v = (a + b + cc + d) / 4;
                    end else begin
                        v = a;
                        if (b > v) v = b;
                        if (cc > v) v = cc;
                        if (d > v) v = d;
                    end
                    w[k*DW +: DW] = DW'(v);
                end
                exp_q.push_back(w);
            end
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic clear_capture();
        got_q.delete();
        got_end_q.delete();
        got_cyc_q.delete();
        stray_end = 0;
    endtask

    task automatic start_frame(input bit m, input int c, input int r);
        en   = 1'b1;
        mode = m;
        col  = CW'(c);
        row  = CW'(r);
        @(negedge clk);
    endtask

    task automatic drive_frame(input int n, input int gap_max, output int base);
        int gap;
        base = cyc;
        for (int i = 0; i < n; i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (gap) begin
                valid_in = 1'b0;
                @(negedge clk);
            end
            if (i == 0) base = cyc;
            valid_in = 1'b1;
            data_in  = frame_px[i];
            @(negedge clk);
        end
        valid_in = 1'b0;
    endtask

    task automatic end_frame();
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_px2(input logic [7:0] l0[], input logic [7:0] l1[]);
        frame_px.delete();
        for (int i = 0; i < l0.size(); i++) frame_px.push_back({l1[i], l0[i]});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mode = 1'b0; col = '0; row = '0;
        valid_in = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid_out got=%b exp=0", valid_out); end
        n_cmp++; if (pool_end !== 1'b0) begin n_bad++; $display("FAIL reset_pool_end got=%b exp=0", pool_end); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_max_basic();
        int base;
        set_px2('{8'd1, 8'd5, 8'd3, 8'd2, 8'd4, 8'd0, 8'd9, 8'd7},
                '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80});
        clear_capture();
        start_frame(1'b0, 4, 2);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL max_busy_run got=%b exp=1", busy); end
        drive_frame(8, 0, base);
        end_frame();
        n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL max_count got=%0d exp=2", got_q.size()); end
        if (got_q.size() == 2) begin
            n_cmp++; if (got_q[0] !== {8'd60, 8'd5}) begin n_bad++; $display("FAIL max_out0 got=%h exp=%h", got_q[0], {8'd60, 8'd5}); end
            n_cmp++; if (got_q[1] !== {8'd80, 8'd9}) begin n_bad++; $display("FAIL max_out1 got=%h exp=%h", got_q[1], {8'd80, 8'd9}); end
            n_cmp++; if (got_end_q[0] !== 1'b0) begin n_bad++; $display("FAIL max_end0 got=%b exp=0", got_end_q[0]); end
            n_cmp++; if (got_end_q[1] !== 1'b1) begin n_bad++; $display("FAIL max_end1 got=%b exp=1", got_end_q[1]); end
            n_cmp++; if (got_cyc_q[0] != base + 6) begin n_bad++; $display("FAIL max_lat0 got=%0d exp=%0d", got_cyc_q[0], base + 6); end
            n_cmp++; if (got_cyc_q[1] != base + 8) begin n_bad++; $display("FAIL max_lat1 got=%0d exp=%0d", got_cyc_q[1], base + 8); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL max_busy_done got=%b exp=0", busy); end
        n_cmp++; if (data_out !== {8'd80, 8'd9}) begin n_bad++; $display("FAIL max_hold got=%h exp=%h", data_out, {8'd80, 8'd9}); end
    endtask

    task automatic test_avg();
        int base;
        // lane0 window 255,255,255,254 -> 254; lane1 window 0,0,0,3 -> 0
        set_px2('{8'd255, 8'd255, 8'd255, 8'd254}, '{8'd0, 8'd0, 8'd0, 8'd3});
        clear_capture();
        start_frame(1'b1, 2, 2);
        drive_frame(4, 0, base);
        end_frame();
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL avg_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() == 1) begin
            n_cmp++; if (got_q[0] !== {8'd0, 8'd254}) begin n_bad++; $display("FAIL avg_out got=%h exp=%h", got_q[0], {8'd0, 8'd254}); end
            n_cmp++; if (got_end_q[0] !== 1'b1) begin n_bad++; $display("FAIL avg_end got=%b exp=1", got_end_q[0]); end
        end
    endtask

    task automatic test_gaps();
        int base;
        logic [7:0] a, b;
        for (int m = 0; m < 2; m++) begin
            frame_px.delete();
            for (int i = 0; i < 32; i++) begin
                a = 8'((i * 37 + 11 + m * 5) & 255);
                b = 8'((i * 91 + 200 + m * 13) & 255);
                frame_px.push_back({b, a});
            end
            model(m[0], 8, 4);
            clear_capture();
            start_frame(m[0], 8, 4);
            drive_frame(32, 3, base);
            end_frame();
            n_cmp++; if (got_q.size() != 8) begin n_bad++; $display("FAIL gaps_count mode=%0d got=%0d exp=8", m, got_q.size()); end
            for (int i = 0; i < 8 && i < got_q.size(); i++) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL gaps_out mode=%0d idx=%0d got=%h exp=%h", m, i, got_q[i], exp_q[i]); end
            end
            if (got_q.size() == 8) begin
                n_cmp++; if (got_end_q[7] !== 1'b1) begin n_bad++; $display("FAIL gaps_end mode=%0d got=%b exp=1", m, got_end_q[7]); end
            end
        end
    endtask

    task automatic test_abort();
        int base;
        int ends;
        logic [7:0] a, b;
        frame_px.delete();
        for (int i = 0; i < 16; i++) begin
            a = 8'((i * 53 + 7) & 255);
            b = 8'((i * 29 + 100) & 255);
            frame_px.push_back({b, a});
        end
        model(1'b0, 4, 4);
        clear_capture();
        start_frame(1'b0, 4, 4);
        drive_frame(10, 0, base);
        // Drop en with a beat presented in the same cycle.
        en = 1'b0; valid_in = 1'b1; data_in = 16'hFFFF;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        ends = stray_end;
        foreach (got_end_q[i]) ends += int'(got_end_q[i]);
        n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL abort_count got=%0d exp=2", got_q.size()); end
        for (int i = 0; i < 2 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL abort_out idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (ends != 0) begin n_bad++; $display("FAIL abort_pool_end got=%0d exp=0", ends); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", busy); end

        frame_px.delete();
        for (int i = 0; i < 16; i++) begin
            a = 8'((i * 11 + 3) & 255);
            b = 8'((200 - i * 7) & 255);
            frame_px.push_back({b, a});
        end
        model(1'b1, 4, 4);
        clear_capture();
        start_frame(1'b1, 4, 4);
        drive_frame(16, 0, base);
        end_frame();
        n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL restart_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL restart_out idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() == 4) begin
            n_cmp++; if (got_end_q[3] !== 1'b1) begin n_bad++; $display("FAIL restart_end got=%b exp=1", got_end_q[3]); end
        end
    endtask

    task automatic test_illegal();
        int cfgs[3] = '{5, 0, MAX_COL + 2};
        clear_capture();
        for (int i = 0; i < 3; i++) begin
            start_frame(1'b0, cfgs[i], 2);
            valid_in = 1'b1; data_in = 16'h1234;
            @(negedge clk);
            valid_in = 1'b0;
            n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL illegal_cfg_err col=%0d got=%b exp=1", cfgs[i], cfg_err); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL illegal_busy col=%0d got=%b exp=0", cfgs[i], busy); end
            en = 1'b0;
            @(negedge clk);
            n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL illegal_clear col=%0d got=%b exp=0", cfgs[i], cfg_err); end
        end
        n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL illegal_outputs got=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_async_reset();
        int base;
        set_px2('{8'd1, 8'd5, 8'd3, 8'd2, 8'd4, 8'd0, 8'd9, 8'd7},
                '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80});
        clear_capture();
        start_frame(1'b0, 4, 2);
        drive_frame(3, 0, base);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
        n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL arst_data_out got=%h exp=0", data_out); end
        n_cmp++; if (valid_out !== 1'b0 || pool_end !== 1'b0 || cfg_err !== 1'b0) begin
            n_bad++; $display("FAIL arst_flags got=%b%b%b exp=000", valid_out, pool_end, cfg_err);
        end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_capture();
        start_frame(1'b0, 4, 2);
        drive_frame(8, 0, base);
        end_frame();
        n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL arst_count got=%0d exp=2", got_q.size()); end
        if (got_q.size() == 2) begin
            n_cmp++; if (got_q[1] !== {8'd80, 8'd9} || got_end_q[1] !== 1'b1) begin
                n_bad++; $display("FAIL arst_frame got=%h/%b exp=%h/1", got_q[1], got_end_q[1], {8'd80, 8'd9});
            end
        end
    endtask

    task automatic test_back_to_back();
        int base_a, base_b;
        // Frame A (average): lane0 10,20,30,41 -> 25; lane1 all 100 -> 100
        set_px2('{8'd10, 8'd20, 8'd30, 8'd41}, '{8'd100, 8'd100, 8'd100, 8'd100});
        clear_capture();
        start_frame(1'b1, 2, 2);
        drive_frame(4, 0, base_a);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_busy got=%b exp=0", busy); end
        // Gap cycle: en stays high, new mode; this beat must be ignored.
        mode = 1'b0; valid_in = 1'b1; data_in = 16'hFFFF;
        @(negedge clk);
        // Frame B (max): lane0 3,9,1,2 -> 9; lane1 200,7,255,0 -> 255
        set_px2('{8'd3, 8'd9, 8'd1, 8'd2}, '{8'd200, 8'd7, 8'd255, 8'd0});
        drive_frame(4, 0, base_b);
        end_frame();
        n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
        if (got_q.size() == 2) begin
            n_cmp++; if (got_q[0] !== {8'd100, 8'd25}) begin n_bad++; $display("FAIL b2b_out_a got=%h exp=%h", got_q[0], {8'd100, 8'd25}); end
            n_cmp++; if (got_q[1] !== {8'd255, 8'd9}) begin n_bad++; $display("FAIL b2b_out_b got=%h exp=%h", got_q[1], {8'd255, 8'd9}); end
            n_cmp++; if (got_end_q[0] !== 1'b1 || got_end_q[1] !== 1'b1) begin
                n_bad++; $display("FAIL b2b_ends got=%b%b exp=11", got_end_q[0], got_end_q[1]);
            end
            n_cmp++; if (got_cyc_q[1] - got_cyc_q[0] != 5) begin
                n_bad++; $display("FAIL b2b_spacing got=%0d exp=5", got_cyc_q[1] - got_cyc_q[0]);
            end
            n_cmp++; if (base_b != base_a + 5) begin n_bad++; $display("FAIL b2b_driver got=%0d exp=%0d", base_b, base_a + 5); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_max_basic();
        test_avg();
        test_gaps();
        test_abort();
        test_illegal();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
